// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - start/abort request and serial output bundle for serial_pattern_tx
interface serial_pattern_tx_if #(
    parameter int WIDTH = 6,
    parameter int REP_W = 4
);
    logic             start;
    logic             pat_sel;
    logic [WIDTH-1:0] pat_in;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pat_sel, pat_in, reps, abort,
        input  out, valid, busy, done
    );

    modport slave (
        input  start, pat_sel, pat_in, reps, abort,
        output out, valid, busy, done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern source with repeat/gap; SERIAL_PATTERN_TX_PARITY_EN adds a parity bit per copy
module serial_pattern_tx #(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] PATTERN = 6'b110101,
    parameter int               REP_W   = 4,
    parameter int               GAP     = 0
) (
    input  logic                clk,
    input  logic                rstn,
    serial_pattern_tx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic               fin_q, fin_d;
    logic               out_q, out_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               copy_end;
    logic [REP_W-1:0]   rep_left;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    // Output registers hold what is on the wire this cycle; done follows a normal finish by one cycle.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        fin_d     = 1'b0;
        out_d     = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        copy_end  = 1'b0;
        rep_left  = rep_cnt_q - REP_W'(1);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                done_d = fin_q;
                if (bus.start && !bus.abort && (bus.reps != '0) && !busy_q) begin
                    pat_d     = bus.pat_sel ? bus.pat_in : PATTERN;
                    shreg_d   = bus.pat_sel ? bus.pat_in : PATTERN;
                    bit_cnt_d = LAST_IDX;
                    rep_cnt_d = bus.reps;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    par_d     = 1'b0;
`endif
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    if (par_q) begin
                        out_d    = ^pat_q;
                        par_d    = 1'b0;
                        copy_end = 1'b1;
                    end else begin
                        out_d   = shreg_q[WIDTH-1];
                        shreg_d = shreg_q << 1;
                        if (bit_cnt_q == '0) par_d = 1'b1;
                        else                 bit_cnt_d = bit_cnt_q - CW'(1);
                    end
`else
                    out_d   = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                    if (bit_cnt_q == '0) copy_end  = 1'b1;
                    else                 bit_cnt_d = bit_cnt_q - CW'(1);
`endif
                    if (copy_end) begin
                        rep_cnt_d = rep_left;
                        if (rep_left == '0) begin
                            state_d = S_IDLE;
                            fin_d   = 1'b1;
                        end else if (GAP == 0) begin
                            shreg_d   = pat_q;
                            bit_cnt_d = LAST_IDX;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end
                    end
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (gap_cnt_q == '0) begin
                        shreg_d   = pat_q;
                        bit_cnt_d = LAST_IDX;
                        state_d   = S_SHIFT;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            fin_q     <= 1'b0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            fin_q     <= fin_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx, GAP=0 and GAP=3 instances in lockstep
module tb_serial_pattern_tx;
    localparam int W  = 6;
    localparam int RW = 4;
    localparam int G1 = 3;
    localparam logic [W-1:0] PAT = 6'b110101;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    typedef struct {
        int kind;
        int val;
    } item_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int tests = 0;
    int fails = 0;
    item_t q0[$];
    item_t q1[$];
    int busycnt[2];
    int gaprun[2];

    serial_pattern_tx_if #(.WIDTH(W), .REP_W(RW)) if0 ();
    serial_pattern_tx_if #(.WIDTH(W), .REP_W(RW)) if1 ();

    assign if1.start   = if0.start;
    assign if1.pat_sel = if0.pat_sel;
    assign if1.pat_in  = if0.pat_in;
    assign if1.reps    = if0.reps;
    assign if1.abort   = if0.abort;

    serial_pattern_tx #(.WIDTH(W), .PATTERN(PAT), .REP_W(RW), .GAP(0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(if0)
    );
    serial_pattern_tx #(.WIDTH(W), .PATTERN(PAT), .REP_W(RW), .GAP(G1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(if1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int kind, input int val);
        item_t it;
        it.kind = kind;
        it.val  = val;
        if (d == 0) q0.push_back(it);
        else        q1.push_back(it);
    endtask

    // Reference: each copy is the pattern MSB-first (plus even parity), copies separated by g idle cycles.
    task automatic push_frame(input logic [W-1:0] p, input int reps);
        for (int d = 0; d < 2; d++) begin
            int g;
            g = (d == 0) ? 0 : G1;
            for (int c = 0; c < reps; c++) begin
                if (c > 0 && g > 0) push(d, 1, g);
                for (int b = W - 1; b >= 0; b--) push(d, 0, int'(p[b]));
                if (L > W) push(d, 0, $countones(p) % 2);
            end
            push(d, 2, reps * L + (reps - 1) * g);
        end
    endtask

    task automatic pop_chk(input int d, input int kind, input int val, input string name);
        item_t it;
        int empty;
        tests++;
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty != 0) begin
            fails++;
            $display("FAIL %s dut%0d: got kind %0d val %0d, expected no activity", name, d, kind, val);
        end else begin
            if (d == 0) it = q0.pop_front();
            else        it = q1.pop_front();
            if (it.kind != kind || it.val != val) begin
                fails++;
                $display("FAIL %s dut%0d: got kind %0d val %0d, expected kind %0d val %0d",
                         name, d, kind, val, it.kind, it.val);
            end
        end
    endtask

    task automatic mon(input int d, input logic o, input logic v, input logic b, input logic dn);
        if (v) begin
            if (!b) chk($sformatf("valid_without_busy dut%0d", d), int'(b), 1);
            if (gaprun[d] > 0) begin
                pop_chk(d, 1, gaprun[d], "gap_len");
                gaprun[d] = 0;
            end
            pop_chk(d, 0, int'(o), "bit");
        end else begin
            if (o) chk($sformatf("idle_out dut%0d", d), int'(o), 0);
            if (b) gaprun[d]++;
        end
        if (b) busycnt[d]++;
        if (dn) begin
            chk($sformatf("done_busy dut%0d", d), int'(b), 0);
            pop_chk(d, 2, busycnt[d], "done_busy_cycles");
            busycnt[d] = 0;
            gaprun[d]  = 0;
        end else if (!b) begin
            busycnt[d] = 0;
            gaprun[d]  = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            busycnt[0] = 0; busycnt[1] = 0;
            gaprun[0]  = 0; gaprun[1]  = 0;
        end else begin
            mon(0, if0.out, if0.valid, if0.busy, if0.done);
            mon(1, if1.out, if1.valid, if1.busy, if1.done);
        end
    end

    task automatic start_frame(input logic sel, input logic [W-1:0] pin, input int reps, input bit model);
        if0.pat_sel = sel;
        if0.pat_in  = pin;
        if0.reps    = reps[RW-1:0];
        if0.start   = 1'b1;
        if (model && reps != 0) push_frame(sel ? pin : PAT, reps);
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !if0.busy && !if1.busy) begin
                ok = 1;
                break;
            end
        end
        chk({name, "_drain"}, int'(ok), 1);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_out0"},   int'(if0.out),   0);
        chk({name, "_valid0"}, int'(if0.valid), 0);
        chk({name, "_busy0"},  int'(if0.busy),  0);
        chk({name, "_done0"},  int'(if0.done),  0);
        chk({name, "_out1"},   int'(if1.out),   0);
        chk({name, "_valid1"}, int'(if1.valid), 0);
        chk({name, "_busy1"},  int'(if1.busy),  0);
        chk({name, "_done1"},  int'(if1.done),  0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] p;
        if0.start = 1'b0; if0.pat_sel = 1'b0; if0.pat_in = '0; if0.reps = '0; if0.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // default pattern, single copy, first bit one cycle after acceptance
        start_frame(1'b0, 6'b000000, 1, 1);
        chk("latency_pre_valid", int'(if0.valid), 0);
        @(negedge clk);
        chk("latency_valid", int'(if0.valid), 1);
        chk("latency_msb",   int'(if0.out),   1);
        chk("latency_busy",  int'(if0.busy),  1);
        wait_drain("single");

        start_frame(1'b0, 6'b000000, 2, 1);
        wait_drain("two_copies");

        p = 6'b101100;
        start_frame(1'b1, p, 3, 1);
        wait_drain("three_copies_runtime");

        start_frame(1'b1, 6'b111111, 0, 1);
        repeat (5) begin
            @(negedge clk);
            chk("reps0_busy", int'(if0.busy), 0);
            chk("reps0_done", int'(if0.done), 0);
        end
        wait_drain("reps0");

        start_frame(1'b0, 6'b000000, 3, 1);
        @(negedge clk);
        chk("restart_busy", int'(if0.busy), 1);
        if0.pat_sel = 1'b1; if0.pat_in = 6'b011011; if0.reps = 4'd2; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        wait_drain("restart_ignored");

        // abort while the third bit of the first copy is on the wire
        p = 6'b100111;
        start_frame(1'b1, p, 2, 0);
        for (int d = 0; d < 2; d++)
            for (int b = W - 1; b >= W - 3; b--) push(d, 0, int'(p[b]));
        repeat (3) @(negedge clk);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        chk_zero("abort");
        repeat (4) @(negedge clk);
        start_frame(1'b0, 6'b000000, 1, 1);
        wait_drain("after_abort");

        if0.abort = 1'b1;
        start_frame(1'b0, 6'b000000, 2, 0);
        if0.abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_start_idle_busy", int'(if0.busy), 0);
        end
        wait_drain("abort_start_idle");

        for (int n = 0; n < 30; n++) begin
            logic sel;
            int r;
            sel = 1'($urandom);
            p   = W'($urandom);
            r   = int'($urandom_range(0, 4));
            start_frame(sel, p, r, 1);
            if (r != 0 && ($urandom % 3) == 0) begin
                @(negedge clk);
                if0.reps = 4'd5; if0.start = 1'b1;
                @(negedge clk);
                if0.start = 1'b0;
            end
            wait_drain("random");
        end

        // asynchronous reset mid-frame clears outputs before the next edge
        start_frame(1'b1, 6'b110011, 3, 1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk_zero("async_reset");
        q0.delete();
        q1.delete();
        @(negedge clk);
        #1 rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_reset_busy",  int'(if0.busy | if1.busy),   0);
            chk("post_reset_valid", int'(if0.valid | if1.valid), 0);
        end

        chk("final_queue0", q0.size(), 0);
        chk("final_queue1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial pattern transmitter. It is the source end of the single-bit serial stream that feeds the pattern detectors (for example the 110101 detector). It loads a WIDTH-bit pattern, either the built-in default or a runtime value, and shifts it out MSB-first one bit per clock. It can repeat the frame a programmable number of times, with an optional idle gap between copies. It has a start/busy/done handshake and gives the detector benches a synthesizable stimulus source.

Parameters:
WIDTH, 6, pattern length in bits (must be ≥2).
PATTERN, 6'b110101, default pattern, used when pat_sel=0.
REP_W, 4, width of the repeat-count input.
GAP, 0, idle cycles inserted between repeated copies (0 = back-to-back).

Ports:
clk  in  1  system clock, all logic on rising edge.
rstn  in  1  asynchronous active-low reset.
start  in  1  request a transmission; sampled only in IDLE.
pat_sel  in  1  0 = use PATTERN, 1 = use pat_in; sampled with start.
pat_in  in  WIDTH  runtime pattern; sampled with start.
reps  in  REP_W  number of frame copies; sampled with start.
abort  in  1  synchronous abort of the current transmission.
out  out  1  serial data bit, registered; connects to the detector's in.
valid  out  1  high while out carries a pattern (or parity) bit.
busy  out  1  high from the cycle after start is accepted until return to IDLE.
done  out  1  one-cycle pulse after the last bit of the last copy.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State goes to IDLE.
  - out=0, valid=0, busy=0, done=0.
  - Shift register, bit counter and repeat counter are cleared.
  - Reset asserted mid-frame truncates the frame immediately; no done pulse.
- Outputs: all are registered, with no combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - out=0, valid=0, busy=0.
  - Start is accepted when start=1 && reps!=0 at edge N:
    - latch the pattern (pat_sel ? pat_in : PATTERN);
    - latch rep_cnt = reps and set bit_cnt = WIDTH-1;
    - go to SHIFT.
  - start=1 with reps==0 is ignored: stay in IDLE, no busy, no done.
- Latency: start accepted at edge N → first bit (pattern MSB) on out with valid=1 and busy=1 after edge N+1.
- SHIFT:
  - Each cycle, out = shreg[WIDTH-1], then shift left by one and decrement bit_cnt.
  - One copy occupies exactly WIDTH consecutive valid cycles.
  - After the last bit (bit_cnt==0), decrement rep_cnt, then:
    - if copies remain and GAP==0: reload the latched pattern and continue in SHIFT with no bubble;
    - if copies remain and GAP>0: go to GAP;
    - if no copies remain: go to IDLE.
- GAP:
  - Hold out=0, valid=0, busy=1 for exactly GAP cycles.
  - Then reload the pattern and return to SHIFT.
- done:
  - Asserted for one cycle, on the first IDLE cycle after the final bit.
  - busy=0 in that same cycle.
- Frame length: total busy cycles = reps×WIDTH + (reps-1)×GAP.
- start while busy=1 is ignored; no queuing.
- abort=1 in SHIFT or GAP:
  - return to IDLE at the next edge with out=0, valid=0, busy=0;
  - no done pulse.
- abort and start together in IDLE: abort wins, start is ignored.
- abort in IDLE has no effect.
- Counters: rep_cnt is REP_W bits and bit_cnt is $clog2(WIDTH) bits; neither wraps, because transitions occur at zero.
- Simultaneous events: reps=1 with GAP>0 never enters GAP.

Optional Feature:
SERIAL_PATTERN_TX_PARITY_EN
- Defined: after the last pattern bit of each copy, one extra SHIFT cycle sends the even-parity bit (XOR of the latched pattern) with valid=1.
  - Copy length becomes WIDTH+1; gap and done timing shift accordingly.
  - For 110101 the parity bit is 0.
- Undefined: no parity cycle; copy length is WIDTH.

Test Plan:
- Defaults, reps=1, pat_sel=0, start pulsed one cycle:
  - out = 1,1,0,1,0,1 on 6 consecutive valid cycles starting one cycle after start;
  - done high on cycle 7;
  - a connected det_110101 pulses out exactly once.
- reps=2, GAP=0:
  - out = 110101110101 with no bubble, busy for 12 cycles;
  - the detector fires twice (overlap handled), done once.
- GAP=3 build, reps=3, pat_sel=1, pat_in=6'b101100:
  - 101100, 0 0 0 (valid=0), 101100, 000, 101100;
  - busy for 24 cycles, done after the final 0.
- Handshake edge cases:
  - start with reps=0 → busy stays 0, no done;
  - a second start pulse during busy → ignored, frame count unchanged.
- abort at the 3rd bit of the first copy (reps=2):
  - next cycle out=0, valid=0, busy=0;
  - done never pulses;
  - a new start is accepted and a full frame is sent.
- rstn=0 asserted asynchronously mid-frame:
  - out, valid, busy and done go to 0 immediately (before the next edge);
  - after release, the block idles until start.
